// File: rtl/cic_d.sv
// CIC decimator: m integrators at the input rate, decimation by r, then m comb
// stages (differential delay g) evaluated once per decimated sample.
module cic_d #(
  parameter int unsigned dw = 10,
  parameter int unsigned r  = 4,
  parameter int unsigned m  = 4,
  parameter int unsigned g  = 1,
  localparam int unsigned W = dw + m * $clog2(r * g)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [dw-1:0] data_in,
  input  logic                 in_dv,
  output logic signed [W-1:0]  data_out,
  output logic                 out_dv
);

  localparam int unsigned CW = $clog2(r);
  localparam logic [CW-1:0] LAST = CW'(r - 1);

  logic signed [W-1:0] int_0;
  logic signed [W-1:0] integ [m];
  logic signed [W-1:0] dec_reg;
  logic signed [W-1:0] dly [m][g];
  logic signed [W-1:0] c_in [m];
  logic signed [W-1:0] c_out;
  logic signed [W-1:0] acc;
  logic [CW-1:0]       phase;
  logic                dec_stb;

  assign int_0 = {{(W - dw){data_in[dw-1]}}, data_in};

  // Comb chain is only consumed on the dec_stb cycle; c_in keeps each stage's
  // input so the delay lines can be shifted on the same edge.
  always_comb begin
    acc = dec_reg;
    for (int unsigned k = 0; k < m; k++) begin
      c_in[k] = acc;
      acc     = acc - dly[k][g-1];
    end
    c_out = acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < m; k++) begin
        integ[k] <= '0;
        for (int unsigned j = 0; j < g; j++) dly[k][j] <= '0;
      end
      dec_reg  <= '0;
      phase    <= '0;
      dec_stb  <= 1'b0;
      data_out <= '0;
      out_dv   <= 1'b0;
    end else begin
      dec_stb <= in_dv && (phase == LAST);
      out_dv  <= dec_stb;
      if (in_dv) begin
        integ[0] <= integ[0] + int_0;
        for (int unsigned k = 1; k < m; k++) integ[k] <= integ[k] + integ[k-1];
        phase <= (phase == LAST) ? '0 : phase + 1'b1;
        if (phase == LAST) dec_reg <= integ[m-1];
      end
      if (dec_stb) begin
        data_out <= c_out;
        for (int unsigned k = 0; k < m; k++) begin
          dly[k][0] <= c_in[k];
          for (int unsigned j = 1; j < g; j++) dly[k][j] <= dly[k][j-1];
        end
      end
    end
  end

endmodule
